// File: rtl/mxs_pkg.sv
// Shared types and constants for the masked XOR sequencer: FSM state encoding,
// LFSR feedback taps, settle-counter width and evaluation-counter ceiling.
package mxs_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EVAL = 2'd1,
    HOLD = 2'd2
  } mxs_state_t;

  localparam int          MXS_CNT_W     = 4;
  // Feedback taps for x^16+x^14+x^13+x^11+1 (bits 15, 13, 12, 10).
  localparam logic [15:0] MXS_LFSR_TAPS = 16'hB400;
  localparam logic [15:0] MXS_EVAL_MAX  = 16'hFFFF;

endpackage

// File: rtl/XOR_TransmissionGate_masked.sv
// First-order masked XOR gadget. Each output share is re-masked with the parity
// of three fresh random bits, so XOR0^XOR1 == A0^A1^B0^B1 for any r.
module XOR_TransmissionGate_masked (
  input  logic A0,
  input  logic A1,
  input  logic B0,
  input  logic B1,
  input  logic r0,
  input  logic r1,
  input  logic r2,
  output logic XOR0,
  output logic XOR1
);

  logic mask;

  assign mask = r0 ^ r1 ^ r2;
  assign XOR0 = (A0 ^ B0) ^ mask;
  assign XOR1 = (A1 ^ B1) ^ mask;

endmodule

// File: rtl/mxs_lfsr.sv
// 16-bit Fibonacci LFSR randomness source for the masked XOR sequencer.
// Advances every cycle out of reset; exposes its three low bits.
module mxs_lfsr
  import mxs_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic       clk,
  input  logic       rst,
  output logic [2:0] rnd_o
);

  logic [15:0] lfsr_q;
  logic [15:0] lfsr_d;

  always_comb begin
    lfsr_d = {lfsr_q[14:0], ^(lfsr_q & MXS_LFSR_TAPS)};
  end

  always_ff @(posedge clk) begin
    if (rst) lfsr_q <= SEED;
    else     lfsr_q <= lfsr_d;
  end

  assign rnd_o = lfsr_q[2:0];

endmodule

// File: rtl/masked_xor_sequencer.sv
// Sequencer driving XOR_TransmissionGate_masked: accept shares, settle, capture, hand off.
// Define MXS_LFSR_EN to use the internal LFSR instead of the external rnd_i/rnd_valid_i port.
module masked_xor_sequencer
  import mxs_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 1,
  parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        A0,
  input  logic        A1,
  input  logic        B0,
  input  logic        B1,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        XOR0,
  output logic        XOR1,
  output logic        busy,
  output logic [15:0] eval_count
`ifndef MXS_LFSR_EN
  ,
  input  logic        rnd_valid_i,
  input  logic [2:0]  rnd_i,
  output logic        rnd_ready_o
`endif
);

  localparam logic [MXS_CNT_W-1:0] SETTLE_INIT = SETTLE_CYCLES[MXS_CNT_W-1:0];
  localparam logic [MXS_CNT_W-1:0] CNT_ONE     = 1;

  if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 15) begin : g_bad_settle
    $error("SETTLE_CYCLES must be in 1..15");
  end
  if (LFSR_SEED == 16'h0000) begin : g_bad_seed
    $error("LFSR_SEED must be non-zero");
  end

  mxs_state_t           state_q, state_d;
  logic [MXS_CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]           opnd_q, opnd_d;    // {B1, B0, A1, A0}
  logic [2:0]           rnd_q, rnd_d;
  logic                 xor0_q, xor0_d, xor1_q, xor1_d;
  logic                 out_valid_q, out_valid_d;
  logic [15:0]          eval_count_q, eval_count_d;

  logic [2:0] rnd_src;
  logic       rnd_avail;
  logic       accept;
  logic       g_xor0, g_xor1;

`ifdef MXS_LFSR_EN
  mxs_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
    .clk   (clk),
    .rst   (rst),
    .rnd_o (rnd_src)
  );
  assign rnd_avail = 1'b1;
`else
  assign rnd_src     = rnd_i;
  assign rnd_avail   = rnd_valid_i;
  assign rnd_ready_o = accept;
`endif

  assign in_ready = !rst && (state_q == IDLE) && rnd_avail;
  assign accept   = in_valid && in_ready;

  // Gadget sees only registered shares, which are zero outside EVAL.
  XOR_TransmissionGate_masked u_gadget (
    .A0   (opnd_q[0]),
    .A1   (opnd_q[1]),
    .B0   (opnd_q[2]),
    .B1   (opnd_q[3]),
    .r0   (rnd_q[0]),
    .r1   (rnd_q[1]),
    .r2   (rnd_q[2]),
    .XOR0 (g_xor0),
    .XOR1 (g_xor1)
  );

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    opnd_d       = opnd_q;
    rnd_d        = rnd_q;
    xor0_d       = xor0_q;
    xor1_d       = xor1_q;
    out_valid_d  = out_valid_q;
    eval_count_d = eval_count_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          opnd_d  = {B1, B0, A1, A0};
          rnd_d   = rnd_src;
          cnt_d   = SETTLE_INIT;
          state_d = EVAL;
        end
      end
      EVAL: begin
        if (cnt_q == '0) begin
          xor0_d      = g_xor0;
          xor1_d      = g_xor1;
          out_valid_d = 1'b1;
          if (eval_count_q != MXS_EVAL_MAX) eval_count_d = eval_count_q + 16'd1;
          opnd_d      = '0;
          rnd_d       = '0;
          state_d     = HOLD;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      HOLD: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      opnd_q       <= '0;
      rnd_q        <= '0;
      xor0_q       <= 1'b0;
      xor1_q       <= 1'b0;
      out_valid_q  <= 1'b0;
      eval_count_q <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      opnd_q       <= opnd_d;
      rnd_q        <= rnd_d;
      xor0_q       <= xor0_d;
      xor1_q       <= xor1_d;
      out_valid_q  <= out_valid_d;
      eval_count_q <= eval_count_d;
    end
  end

  assign XOR0       = xor0_q;
  assign XOR1       = xor1_q;
  assign out_valid  = out_valid_q;
  assign busy       = (state_q != IDLE);
  assign eval_count = eval_count_q;

endmodule

// File: tb/tb_masked_xor_sequencer.sv
// Directed testbench for masked_xor_sequencer (SETTLE_CYCLES=1).
// Primarily targets the default build; MXS_LFSR_EN switches the port list and r-dependent checks.
module tb_masked_xor_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready;
  logic        A0, A1, B0, B1;
  logic        out_valid, out_ready;
  logic        XOR0, XOR1, busy;
  logic [15:0] eval_count;
  logic        rnd_valid_i;
  logic [2:0]  rnd_i;
  logic        rnd_ready_o;

  int n_tests = 0;
  int n_fail  = 0;
  int exp_evals = 0;

  always #5 clk = ~clk;

  masked_xor_sequencer #(.SETTLE_CYCLES(1), .LFSR_SEED(16'hACE1)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .A0         (A0),
    .A1         (A1),
    .B0         (B0),
    .B1         (B1),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .XOR0       (XOR0),
    .XOR1       (XOR1),
    .busy       (busy),
    .eval_count (eval_count)
`ifndef MXS_LFSR_EN
    ,
    .rnd_valid_i(rnd_valid_i),
    .rnd_i      (rnd_i),
    .rnd_ready_o(rnd_ready_o)
`endif
  );

`ifdef MXS_LFSR_EN
  assign rnd_ready_o = 1'b0;
`endif

  // Advance one clock and settle just past the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    A0 = 1'b0; A1 = 1'b0; B0 = 1'b0; B1 = 1'b0;
    rnd_valid_i = 1'b1; rnd_i = 3'b000;
    for (int i = 0; i < 3; i++) begin
      step();
      n_tests++;
      if ({in_ready, out_valid, XOR0, XOR1, busy} !== 5'b0 || eval_count !== 16'd0 || rnd_ready_o !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_outputs cycle %0d: in_ready=%b out_valid=%b XOR=%b%b busy=%b eval_count=%0d, required all 0",
                 i, in_ready, out_valid, XOR0, XOR1, busy, eval_count);
      end
    end
    rst = 1'b0;
    #1;
    n_tests++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_release_in_ready: got %b, required 1", in_ready);
    end
    $display("[TB] reset: released, eval_count=%0d", eval_count);
  endtask

  task automatic test_single();
    A0 = 1'b1; A1 = 1'b0; B0 = 1'b1; B1 = 1'b1;
    rnd_i = 3'b010; rnd_valid_i = 1'b1; in_valid = 1'b1; out_ready = 1'b0;
    #1;
`ifndef MXS_LFSR_EN
    n_tests++;
    if (rnd_ready_o !== 1'b1) begin
      n_fail++;
      $display("FAIL single_rnd_ready: got %b, required 1", rnd_ready_o);
    end
`endif
    step();                                  // accept edge T
    in_valid = 1'b0;
    A0 = 1'b0; A1 = 1'b1; B0 = 1'b0; B1 = 1'b0; rnd_i = 3'b111;
    n_tests++;
    if (busy !== 1'b1 || in_ready !== 1'b0 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL single_eval_state: busy=%b in_ready=%b out_valid=%b, required 1 0 0", busy, in_ready, out_valid);
    end
    step();                                  // T+1
    n_tests++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL single_early_valid: out_valid=%b after T+1, required 0", out_valid);
    end
    step();                                  // T+2
    exp_evals++;
    n_tests++;
    if (out_valid !== 1'b1 || (XOR0 ^ XOR1) !== 1'b1 || eval_count !== 16'(exp_evals)) begin
      n_fail++;
      $display("FAIL single_result: out_valid=%b XOR0^XOR1=%b eval_count=%0d, required 1 1 %0d",
               out_valid, XOR0 ^ XOR1, eval_count, exp_evals);
    end
`ifndef MXS_LFSR_EN
    n_tests++;
    if ({XOR0, XOR1} !== 2'b10) begin
      n_fail++;
      $display("FAIL single_shares: XOR0,XOR1=%b%b, required 10", XOR0, XOR1);
    end
`endif
    $display("[TB] single: A=10 B=11 -> XOR0=%b XOR1=%b eval_count=%0d", XOR0, XOR1, eval_count);
  endtask

  task automatic test_backpressure();
    logic x0, x1;
    x0 = XOR0; x1 = XOR1;
    for (int i = 0; i < 5; i++) begin
      step();
      n_tests++;
      if (out_valid !== 1'b1 || XOR0 !== x0 || XOR1 !== x1 || in_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL backpressure_hold cycle %0d: out_valid=%b XOR=%b%b in_ready=%b, required 1 %b%b 0",
                 i, out_valid, XOR0, XOR1, in_ready, x0, x1);
      end
    end
    out_ready = 1'b1;
    step();
    n_tests++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || XOR0 !== x0 || XOR1 !== x1 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL backpressure_release: out_valid=%b busy=%b XOR=%b%b in_ready=%b, required 0 0 %b%b 1",
               out_valid, busy, XOR0, XOR1, in_ready, x0, x1);
    end
    $display("[TB] backpressure: held 5 cycles, released to IDLE");
  endtask

  task automatic test_back_to_back();
    // {A0,A1,B0,B1}, {r2,r1,r0}, expected {XOR0,XOR1}
    logic [3:0] ops [3] = '{4'b1101, 4'b0000, 4'b1001};
    logic [2:0] rs  [3] = '{3'b111, 3'b011, 3'b100};
    logic [1:0] exp [3] = '{2'b01, 2'b00, 2'b00};
    logic [3:0] op;
    logic [1:0] ex;
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      op = ops[k];
      ex = exp[k];
      {A0, A1, B0, B1} = op;
      rnd_i = rs[k];
      in_valid = 1'b1;
      #1;
      n_tests++;
      if (in_ready !== 1'b1) begin
        n_fail++;
        $display("FAIL b2b_ready txn %0d: in_ready=%b, required 1", k, in_ready);
      end
      step();
      in_valid = 1'b0;
      step();
      step();
      exp_evals++;
      n_tests++;
      if (out_valid !== 1'b1 || (XOR0 ^ XOR1) !== ^op || eval_count !== 16'(exp_evals)) begin
        n_fail++;
        $display("FAIL b2b_result txn %0d: out_valid=%b XOR0^XOR1=%b eval_count=%0d, required 1 %b %0d",
                 k, out_valid, XOR0 ^ XOR1, eval_count, ^op, exp_evals);
      end
`ifndef MXS_LFSR_EN
      n_tests++;
      if ({XOR0, XOR1} !== ex) begin
        n_fail++;
        $display("FAIL b2b_shares txn %0d: XOR0,XOR1=%b%b, required %b", k, XOR0, XOR1, ex);
      end
`endif
      step();
      n_tests++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
        n_fail++;
        $display("FAIL b2b_idle txn %0d: out_valid=%b in_ready=%b, required 0 1", k, out_valid, in_ready);
      end
      $display("[TB] b2b txn %0d: ops=%b r=%b -> XOR0=%b XOR1=%b", k, op, rs[k], XOR0, XOR1);
    end
  endtask

`ifndef MXS_LFSR_EN
  task automatic test_rnd_gate();
    int pulses;
    A0 = 1'b0; A1 = 1'b1; B0 = 1'b1; B1 = 1'b1;
    rnd_valid_i = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      n_tests++;
      if (in_ready !== 1'b0 || busy !== 1'b0 || rnd_ready_o !== 1'b0) begin
        n_fail++;
        $display("FAIL rnd_gate_blocked cycle %0d: in_ready=%b busy=%b rnd_ready_o=%b, required 0 0 0",
                 i, in_ready, busy, rnd_ready_o);
      end
    end
    rnd_valid_i = 1'b1; rnd_i = 3'b101;
    #1;
    pulses = (rnd_ready_o === 1'b1) ? 1 : 0;
    step();                                  // accept edge
    in_valid = 1'b0;
    for (int k = 0; k < 5; k++) begin
      if (rnd_ready_o === 1'b1) pulses++;
      step();
      if (k == 1) begin
        exp_evals++;
        n_tests++;
        if (out_valid !== 1'b1 || {XOR0, XOR1} !== 2'b10 || eval_count !== 16'(exp_evals)) begin
          n_fail++;
          $display("FAIL rnd_gate_result: out_valid=%b XOR=%b%b eval_count=%0d, required 1 10 %0d",
                   out_valid, XOR0, XOR1, eval_count, exp_evals);
        end
      end
    end
    n_tests++;
    if (pulses != 1) begin
      n_fail++;
      $display("FAIL rnd_ready_pulses: got %0d, required 1", pulses);
    end
    $display("[TB] rnd_gate: r=101 accepted, rnd_ready_o pulses=%0d", pulses);
  endtask
`endif

  task automatic test_mid_eval_reset();
    A0 = 1'b1; A1 = 1'b1; B0 = 1'b0; B1 = 1'b1;
    rnd_valid_i = 1'b1; rnd_i = 3'b001; in_valid = 1'b1; out_ready = 1'b1;
    step();                                  // accept
    in_valid = 1'b0;
    step();                                  // in EVAL, capture due next edge
    rst = 1'b1;
    step();
    exp_evals = 0;
    n_tests++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || eval_count !== 16'd0 || in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_eval_abort: out_valid=%b busy=%b eval_count=%0d in_ready=%b, required 0 0 0 0",
               out_valid, busy, eval_count, in_ready);
    end
`ifdef MXS_LFSR_EN
    n_tests++;
    if (dut.u_lfsr.lfsr_q !== 16'hACE1) begin
      n_fail++;
      $display("FAIL mid_eval_lfsr: got %h, required ace1", dut.u_lfsr.lfsr_q);
    end
`endif
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      n_tests++;
      if (out_valid !== 1'b0 || eval_count !== 16'd0) begin
        n_fail++;
        $display("FAIL mid_eval_quiet cycle %0d: out_valid=%b eval_count=%0d, required 0 0", i, out_valid, eval_count);
      end
    end
    $display("[TB] mid_eval_reset: aborted, eval_count=%0d", eval_count);
  endtask

  task automatic test_random();
    logic [31:0] v;
    logic [3:0]  op;
    logic [2:0]  r;
    logic        par;
    out_ready = 1'b1; rnd_valid_i = 1'b1;
    for (int n = 0; n < 1000; n++) begin
      v  = $urandom;
      op = v[3:0];
      r  = v[6:4];
      {A0, A1, B0, B1} = op;
      rnd_i = r;
      in_valid = 1'b1;
      #1;
      n_tests++;
      if (in_ready !== 1'b1) begin
        n_fail++;
        $display("FAIL random_ready txn %0d: in_ready=%b, required 1", n, in_ready);
      end
      step();
      in_valid = 1'b0;
      step();
      step();
      exp_evals++;
      par = ^op;
      n_tests++;
      if (out_valid !== 1'b1 || (XOR0 ^ XOR1) !== par || eval_count !== 16'(exp_evals)) begin
        n_fail++;
        $display("FAIL random_result txn %0d: out_valid=%b XOR0^XOR1=%b eval_count=%0d, required 1 %b %0d",
                 n, out_valid, XOR0 ^ XOR1, eval_count, par, exp_evals);
      end
`ifndef MXS_LFSR_EN
      n_tests++;
      if (XOR0 !== (op[3] ^ op[1] ^ (^r)) || XOR1 !== (op[2] ^ op[0] ^ (^r))) begin
        n_fail++;
        $display("FAIL random_shares txn %0d: XOR=%b%b, required %b%b",
                 n, XOR0, XOR1, op[3] ^ op[1] ^ (^r), op[2] ^ op[0] ^ (^r));
      end
`endif
      $display("[TB] random txn %0d: ops=%b r=%b -> XOR0=%b XOR1=%b", n, op, r, XOR0, XOR1);
      step();
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_backpressure();
    test_back_to_back();
`ifndef MXS_LFSR_EN
    test_rnd_gate();
`endif
    test_mid_eval_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
